// File: rtl/multiply_acc_seq.sv
// Sequential shift-add multiplier with an accumulator and a sticky overflow flag.
// The product takes one multiplier bit per clock, LSB first; DONE holds until consumed.
module multiply_acc_seq #(
  parameter int unsigned A_W    = 3,
  parameter int unsigned B_W    = 3,
  parameter int unsigned ACC_W  = 12,
  parameter bit          SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               acc_en,
  input  logic               clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product,
  output logic [ACC_W-1:0]   result,
  output logic               ovf
);

  localparam int unsigned PW = A_W + B_W;
  localparam int unsigned CW = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(B_W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [B_W-1:0]    b_q, b_d;
  logic              acc_en_q, acc_en_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     pp_q, pp_d;
  logic [PW-1:0]     product_q, product_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;

  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     term;
  logic [PW-1:0]     pp_next;
  logic              last;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum;
  logic              wrap;

  always_comb begin
    a_ext    = SIGNED ? PW'($signed(a)) : PW'(a);
    last     = (cnt_q == LastCnt);
    term     = b_q[0] ? mcand_q : '0;
    // Two's complement: the multiplier MSB carries negative weight.
    pp_next  = (SIGNED && last) ? (pp_q - term) : (pp_q + term);
    prod_ext = SIGNED ? ACC_W'($signed(pp_next)) : ACC_W'(pp_next);
    base     = acc_en_q ? result_q : '0;
    sum      = {1'b0, base} + {1'b0, prod_ext};
    wrap     = SIGNED ? ((base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                         (sum[ACC_W-1] != base[ACC_W-1]))
                      : sum[ACC_W];

    state_d   = state_q;
    mcand_d   = mcand_q;
    b_d       = b_q;
    acc_en_d  = acc_en_q;
    cnt_d     = cnt_q;
    pp_d      = pp_q;
    product_d = product_q;
    result_d  = result_q;
    ovf_d     = ovf_q;

    if (clr) begin
      result_d = '0;
      ovf_d    = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = a_ext;
          b_d      = b;
          acc_en_d = acc_en;
          pp_d     = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        pp_d    = pp_next;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d     = '0;
          product_d = pp_next;
          state_d   = StDone;
          // A coincident clear behaves as an accumulator of zero, which cannot wrap.
          if (clr) begin
            result_d = prod_ext;
            ovf_d    = 1'b0;
          end else begin
            result_d = sum[ACC_W-1:0];
            ovf_d    = ovf_q | (acc_en_q & wrap);
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      b_q       <= '0;
      acc_en_q  <= 1'b0;
      cnt_q     <= '0;
      pp_q      <= '0;
      product_q <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      b_q       <= b_d;
      acc_en_q  <= acc_en_d;
      cnt_q     <= cnt_d;
      pp_q      <= pp_d;
      product_q <= product_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign product   = product_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/multiply_acc_seq.md
MULTIPLY_ACC_SEQ -- requirements
Module: multiply_acc_seq

Interface
REQ-001 SHALL provide parameter A_W, default 3, width of operand a.
REQ-002 SHALL provide parameter B_W, default 3, width of operand b and number of compute cycles.
REQ-003 SHALL provide parameter ACC_W, default 12, accumulator/result width; legal only if ACC_W >= A_W+B_W.
REQ-004 SHALL provide parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Port list, clock and reset first:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands
- a  input  A_W  multiplicand
- b  input  B_W  multiplier
- acc_en  input  1  sampled with operands: 1 = add product to accumulator, 0 = overwrite
- clr  input  1  synchronous clear of accumulator and ovf
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- product  output  A_W+B_W  exact product of last operation
- result  output  ACC_W  accumulator value
- ovf  output  1  sticky accumulator overflow flag

Function
REQ-006 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; no other states.
REQ-007 SHALL drive in_ready = 1 in IDLE only; out_valid = 1 in DONE only.
REQ-008 IDLE: on edge with in_valid=1, SHALL latch a, b, acc_en, clear partial product and bit counter, enter CALC.
REQ-009 CALC: SHALL shift-add one bit of latched b per clock, LSB first, B_W clocks total; a/b/acc_en input changes ignored.
REQ-010 SIGNED=1: SHALL sign-extend a and subtract (not add) the partial term for the MSB of b; SIGNED=0: zero-extend, add all terms.
REQ-011 Latency: accept at edge k -> DONE entered and out_valid high after edge k+B_W, exactly.
REQ-012 On DONE entry SHALL update product with exact A_W+B_W-bit product, and result = (acc_en ? result : 0) + extended product, modulo 2^ACC_W (sign-extend if SIGNED=1).
REQ-013 ovf SHALL set on DONE entry when the accumulate wraps (unsigned carry-out / signed overflow); sticky until clr or reset; overwrite (acc_en=0) never sets it.
REQ-014 DONE: SHALL hold out_valid, product, result, ovf stable until out_ready=1; on that edge return to IDLE.
REQ-015 No overlap: in_valid during CALC or DONE SHALL be ignored (in_ready=0).
REQ-016 In IDLE, product and result SHALL keep last values.
REQ-017 clr=1 on any edge SHALL zero result and ovf; clr does not change state or product.
REQ-018 clr coinciding with DONE entry: SHALL compute result = 0 + extended product, ovf from this operation only.
REQ-019 out_ready in IDLE/CALC SHALL have no effect.

Reset
REQ-020 rst low SHALL immediately force IDLE, product=0, result=0, ovf=0, out_valid=0, counter=0, in_ready=1, regardless of state, including mid-CALC.
REQ-021 After rst rises, first operation SHALL behave exactly as REQ-008..REQ-012 with accumulator 0.

Verification (defaults unless stated)
REQ-022 Reset mid-CALC: rst low during 2nd CALC cycle -> out_valid=0, result=0, product=0, ovf=0, in_ready=1 immediately; no stale out_valid after release.
REQ-023 a=3, b=3, acc_en=0, out_ready=1 -> out_valid exactly 3 clocks after accept edge, product=9, result=9, ovf=0.
REQ-024 Full times table a,b in 0..7, acc_en=0 -> product=a*b every case (7*7=49); one result per handshake, none lost or duplicated.
REQ-025 Back-pressure: out_ready=0 for 5 clocks after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-026 clr, then 84 ops 7*7 acc_en=1 -> after op 83 result=4067 ovf=0; after op 84 result=20 ovf=1; further op keeps ovf=1; clr -> result=0 ovf=0.
REQ-027 SIGNED=1: a=3'b101 (-3), b=3'b011 -> product=6'b110111 (-9), result=12'hFF7; a=-4, b=-4 -> product=16.
